// File: rtl/liteic_slave_node_read_arb.sv
// Slave-side read node: QoS/round-robin/aging AR arbiter with a grant-order FIFO that steers in-order R beats.
// AR and R paths are zero-cycle combinational; a full FIFO stalls AR and an unready head master stalls R.
module liteic_slave_node_read_arb #(
    parameter int NUM_MST    = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int QOS_W      = 4,
    parameter int MAX_OUTST  = 4,
    parameter int AGE_THRESH = 15
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_MST*ADDR_W-1:0]        mst_ar_addr_i,
    input  logic [NUM_MST*QOS_W-1:0]         mst_ar_qos_i,
    input  logic [NUM_MST-1:0]               mst_ar_valid_i,
    output logic [NUM_MST-1:0]               mst_ar_ready_o,
    output logic [NUM_MST-1:0]               mst_r_valid_o,
    input  logic [NUM_MST-1:0]               mst_r_ready_i,
    output logic [DATA_W-1:0]                mst_r_data_o,
    output logic [1:0]                       mst_r_resp_o,
    output logic [ADDR_W-1:0]                slv_ar_addr_o,
    output logic                             slv_ar_valid_o,
    input  logic                             slv_ar_ready_i,
    input  logic [DATA_W-1:0]                slv_r_data_i,
    input  logic [1:0]                       slv_r_resp_i,
    input  logic                             slv_r_valid_i,
    output logic                             slv_r_ready_o,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt_o
);

    localparam int IW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);
    localparam int AGW = (AGE_THRESH > 0) ? $clog2(AGE_THRESH + 1) : 1;

    logic [IW-1:0]     rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [IW-1:0]     lock_idx_q, lock_idx_d;
    logic [AGW-1:0]    age_q [NUM_MST];
    logic [AGW-1:0]    age_d [NUM_MST];
    logic [IW-1:0]     fifo_q [MAX_OUTST];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [ADDR_W-1:0] addr_a [NUM_MST];
    logic [QOS_W-1:0]  qos_a  [NUM_MST];
    logic [QOS_W-1:0]  max_qos;
    logic [NUM_MST-1:0] aged, cand;
    logic [IW-1:0]     arb_idx, gnt_idx, head;
    logic              found;
    int                idx;
    logic              fifo_full, fifo_empty, ar_hs, r_hs;

    always_comb begin
        for (int k = 0; k < NUM_MST; k++) begin
            addr_a[k] = mst_ar_addr_i[k*ADDR_W +: ADDR_W];
            qos_a[k]  = mst_ar_qos_i[k*QOS_W +: QOS_W];
        end
    end

    // Aged requesters pre-empt QoS entirely; both classes share the same rotation.
    always_comb begin
        max_qos = '0;
        aged    = '0;
        cand    = '0;
        arb_idx = rr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            if (mst_ar_valid_i[k] && qos_a[k] > max_qos) max_qos = qos_a[k];
            if (AGE_THRESH != 0 && mst_ar_valid_i[k] && age_q[k] == AGW'(AGE_THRESH)) aged[k] = 1'b1;
        end
        for (int k = 0; k < NUM_MST; k++)
            cand[k] = mst_ar_valid_i[k] && (qos_a[k] == max_qos);
        if (|aged) cand = aged;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_MST) idx = idx - NUM_MST;
            if (!found && cand[idx]) begin
                arb_idx = IW'(idx);
                found   = 1'b1;
            end
        end
    end

    // A presented-but-unaccepted grant is held so the AR payload stays stable.
    assign gnt_idx        = (lock_q && mst_ar_valid_i[lock_idx_q]) ? lock_idx_q : arb_idx;
    assign fifo_full      = (cnt_q == CW'(MAX_OUTST));
    assign fifo_empty     = (cnt_q == '0);
    assign slv_ar_valid_o = (|mst_ar_valid_i) && !fifo_full;
    assign slv_ar_addr_o  = addr_a[gnt_idx];
    assign ar_hs          = slv_ar_valid_o && slv_ar_ready_i;
    assign mst_ar_ready_o = ar_hs ? (NUM_MST'(1) << gnt_idx) : '0;

    assign head           = fifo_q[rd_q];
    assign slv_r_ready_o  = mst_r_ready_i[head] && !fifo_empty;
    assign mst_r_valid_o  = (slv_r_valid_i && !fifo_empty) ? (NUM_MST'(1) << head) : '0;
    assign r_hs           = slv_r_valid_i && slv_r_ready_o;
    assign mst_r_data_o   = slv_r_data_i;
    assign mst_r_resp_o   = slv_r_resp_i;
    assign outst_cnt_o    = cnt_q;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = slv_ar_valid_o && !slv_ar_ready_i;
        lock_idx_d = gnt_idx;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q + CW'(ar_hs) - CW'(r_hs);
        if (ar_hs) begin
            rr_d = (gnt_idx == IW'(NUM_MST - 1)) ? '0 : gnt_idx + IW'(1);
            wr_d = (MAX_OUTST == 1) ? '0 : wr_q + PW'(1);
        end
        if (r_hs) rd_d = (MAX_OUTST == 1) ? '0 : rd_q + PW'(1);
        for (int k = 0; k < NUM_MST; k++) begin
            age_d[k] = age_q[k];
            if (!mst_ar_valid_i[k])
                age_d[k] = '0;
            else if (ar_hs && gnt_idx == IW'(k))
                age_d[k] = '0;
            else if (age_q[k] < AGW'(AGE_THRESH))
                age_d[k] = age_q[k] + AGW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < NUM_MST; k++) age_q[k] <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            for (int k = 0; k < NUM_MST; k++) age_q[k] <= age_d[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (ar_hs) fifo_q[wr_q] <= gnt_idx;
    end

endmodule

// File: tb/tb_liteic_slave_node_read_arb.sv
// Directed bench for the slave read node: single read, QoS order, grant lock, aging, full FIFO, reset.
module tb_liteic_slave_node_read_arb;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int QW = 4;
    localparam int MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NM*AW-1:0]  mst_ar_addr_i;
    logic [NM*QW-1:0]  mst_ar_qos_i;
    logic [NM-1:0]     mst_ar_valid_i;
    logic [NM-1:0]     mst_ar_ready_o;
    logic [NM-1:0]     mst_r_valid_o;
    logic [NM-1:0]     mst_r_ready_i;
    logic [DW-1:0]     mst_r_data_o;
    logic [1:0]        mst_r_resp_o;
    logic [AW-1:0]     slv_ar_addr_o;
    logic              slv_ar_valid_o;
    logic              slv_ar_ready_i;
    logic [DW-1:0]     slv_r_data_i;
    logic [1:0]        slv_r_resp_i;
    logic              slv_r_valid_i;
    logic              slv_r_ready_o;
    logic [2:0]        outst_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    liteic_slave_node_read_arb #(
        .NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .QOS_W(QW), .MAX_OUTST(MO), .AGE_THRESH(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mst_ar_addr_i(mst_ar_addr_i), .mst_ar_qos_i(mst_ar_qos_i),
        .mst_ar_valid_i(mst_ar_valid_i), .mst_ar_ready_o(mst_ar_ready_o),
        .mst_r_valid_o(mst_r_valid_o), .mst_r_ready_i(mst_r_ready_i),
        .mst_r_data_o(mst_r_data_o), .mst_r_resp_o(mst_r_resp_o),
        .slv_ar_addr_o(slv_ar_addr_o), .slv_ar_valid_o(slv_ar_valid_o),
        .slv_ar_ready_i(slv_ar_ready_i), .slv_r_data_i(slv_r_data_i),
        .slv_r_resp_i(slv_r_resp_i), .slv_r_valid_i(slv_r_valid_i),
        .slv_r_ready_o(slv_r_ready_o), .outst_cnt_o(outst_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1ns after it and checked 1ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [QW-1:0] q, input logic v);
        mst_ar_addr_i[k*AW +: AW] = a;
        mst_ar_qos_i[k*QW +: QW]  = q;
        mst_ar_valid_i[k]         = v;
    endtask

    task automatic do_reset();
        rst_i          = 1'b1;
        mst_ar_addr_i  = '0;
        mst_ar_qos_i   = '0;
        mst_ar_valid_i = '0;
        mst_r_ready_i  = '0;
        slv_ar_ready_i = 1'b0;
        slv_r_data_i   = '0;
        slv_r_resp_i   = '0;
        slv_r_valid_i  = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_outst", outst_cnt_o, 0);
        chk("rst_arvld", slv_ar_valid_o, 0);
        chk("rst_rrdy", slv_r_ready_o, 0);
        chk("rst_mrvld", mst_r_valid_o, 0);

        // Single read from slot 2
        step();
        set_slot(2, 32'h100, 3, 1'b1);
        slv_ar_ready_i = 1'b1;
        #1;
        chk("sgl_addr", slv_ar_addr_o, 32'h100);
        chk("sgl_arrdy", mst_ar_ready_o, 4'b0100);
        step();
        set_slot(2, 32'h100, 3, 1'b0);
        slv_r_valid_i = 1'b1;
        slv_r_data_i  = 32'hDEADBEEF;
        slv_r_resp_i  = 2'b10;
        mst_r_ready_i = 4'hF;
        #1;
        chk("sgl_outst1", outst_cnt_o, 1);
        chk("sgl_rvld", mst_r_valid_o, 4'b0100);
        chk("sgl_rdata", mst_r_data_o, 32'hDEADBEEF);
        chk("sgl_rresp", mst_r_resp_o, 2'b10);
        step();
        slv_r_valid_i = 1'b0;
        #1;
        chk("sgl_outst0", outst_cnt_o, 0);

        // QoS order 1,3,0 from rr_ptr=0
        do_reset();
        set_slot(0, 32'hA000, 2, 1'b1);
        set_slot(1, 32'hA100, 7, 1'b1);
        set_slot(3, 32'hA300, 7, 1'b1);
        slv_ar_ready_i = 1'b1;
        #1;
        chk("qos_g1", mst_ar_ready_o, 4'b0010);
        chk("qos_a1", slv_ar_addr_o, 32'hA100);
        step();
        mst_ar_valid_i[1] = 1'b0;
        #1;
        chk("qos_g2", mst_ar_ready_o, 4'b1000);
        chk("qos_a2", slv_ar_addr_o, 32'hA300);
        step();
        mst_ar_valid_i[3] = 1'b0;
        #1;
        chk("qos_g3", mst_ar_ready_o, 4'b0001);
        step();
        mst_ar_valid_i[0] = 1'b0;
        slv_r_valid_i = 1'b1;
        mst_r_ready_i = 4'hF;
        #1;
        chk("qos_outst3", outst_cnt_o, 3);
        chk("qos_r1", mst_r_valid_o, 4'b0010);
        step();
        #1;
        chk("qos_r2", mst_r_valid_o, 4'b1000);
        step();
        #1;
        chk("qos_r3", mst_r_valid_o, 4'b0001);
        step();
        slv_r_valid_i = 1'b0;
        #1;
        chk("qos_outst0", outst_cnt_o, 0);

        // Grant lock: slot 0 held while slot 1 (higher QoS) waits
        do_reset();
        set_slot(0, 32'hA0, 1, 1'b1);
        #1;
        chk("lck_c0", slv_ar_addr_o, 32'hA0);
        chk("lck_c0rdy", mst_ar_ready_o, 0);
        step();
        set_slot(1, 32'hB0, 15, 1'b1);
        #1;
        chk("lck_c1", slv_ar_addr_o, 32'hA0);
        step();
        #1;
        chk("lck_c2", slv_ar_addr_o, 32'hA0);
        step();
        slv_ar_ready_i = 1'b1;
        #1;
        chk("lck_c3", slv_ar_addr_o, 32'hA0);
        chk("lck_c3rdy", mst_ar_ready_o, 4'b0001);
        step();
        mst_ar_valid_i[0] = 1'b0;
        #1;
        chk("lck_c4", slv_ar_addr_o, 32'hB0);
        chk("lck_c4rdy", mst_ar_ready_o, 4'b0010);
        step();
        mst_ar_valid_i[1] = 1'b0;
        #1;
        chk("lck_outst2", outst_cnt_o, 2);

        // Reset with two reads outstanding, then a stray R beat
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("rmid_outst", outst_cnt_o, 0);
        chk("rmid_arvld", slv_ar_valid_o, 0);
        slv_r_valid_i = 1'b1;
        mst_r_ready_i = 4'hF;
        #1;
        chk("rmid_rrdy", slv_r_ready_o, 0);
        chk("rmid_mrvld", mst_r_valid_o, 0);

        // Aging: slot 3 (qos 0) overtakes slot 0 (qos 15) after 4 waits
        do_reset();
        set_slot(0, 32'h0, 15, 1'b1);
        set_slot(3, 32'h3, 0, 1'b1);
        slv_ar_ready_i = 1'b1;
        slv_r_valid_i  = 1'b1;
        mst_r_ready_i  = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("age_c%0d", c), mst_ar_ready_o, 4'b0001);
            step();
        end
        #1;
        chk("age_c4", mst_ar_ready_o, 4'b1000);
        step();
        mst_ar_valid_i = '0;
        step();
        #1;
        chk("age_drain", outst_cnt_o, 0);

        // Full FIFO blocks AR, including in the cycle that pops
        do_reset();
        set_slot(2, 32'h200, 0, 1'b1);
        slv_ar_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("full_g%0d", c), mst_ar_ready_o, 4'b0100);
            step();
        end
        #1;
        chk("full_arvld", slv_ar_valid_o, 0);
        chk("full_outst", outst_cnt_o, 4);
        chk("full_arrdy", mst_ar_ready_o, 0);
        step();
        slv_r_valid_i = 1'b1;
        mst_r_ready_i = 4'hF;
        #1;
        chk("full_popblk", slv_ar_valid_o, 0);
        chk("full_rvld", mst_r_valid_o, 4'b0100);
        step();
        slv_r_valid_i = 1'b0;
        #1;
        chk("full_resume", slv_ar_valid_o, 1);
        chk("full_outst3", outst_cnt_o, 3);
        step();
        #1;
        chk("full_refill", outst_cnt_o, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/liteic_slave_node_read_arb.md
Name: liteic_slave_node_read_arb

Overview:
Slave-side read node of the liteic crossbar. It arbitrates AR requests from NUM_MST master slots onto one AXI-lite slave port. The winner is chosen by highest ARQOS, with round-robin tie-break and an aging escalation that prevents starvation. Up to MAX_OUTST reads can be in flight; a grant-order FIFO routes in-order R responses back to the issuing master.

Parameters:
NUM_MST, 4, number of master slots (1..32)
ADDR_W, 32, AR address width
DATA_W, 32, R data width
QOS_W, 4, ARQOS width
MAX_OUTST, 4, maximum outstanding reads; depth of the grant FIFO (power of two, >=1)
AGE_THRESH, 15, wait cycles before a requester is escalated; 0 disables aging

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
mst_ar_addr_i  in  NUM_MST*ADDR_W  per-slot AR address, slot k at [k*ADDR_W +: ADDR_W]
mst_ar_qos_i  in  NUM_MST*QOS_W  per-slot ARQOS
mst_ar_valid_i  in  NUM_MST  per-slot AR valid
mst_ar_ready_o  out  NUM_MST  per-slot AR ready, onehot or zero
mst_r_valid_o  out  NUM_MST  per-slot R valid, onehot or zero
mst_r_ready_i  in  NUM_MST  per-slot R ready
mst_r_data_o  out  DATA_W  R data, broadcast to all slots
mst_r_resp_o  out  2  R resp, broadcast to all slots
slv_ar_addr_o  out  ADDR_W  AR address to slave
slv_ar_valid_o  out  1  AR valid to slave
slv_ar_ready_i  in  1  AR ready from slave
slv_r_data_i  in  DATA_W  R data from slave
slv_r_resp_i  in  2  R resp from slave
slv_r_valid_i  in  1  R valid from slave
slv_r_ready_o  out  1  R ready to slave
outst_cnt_o  out  $clog2(MAX_OUTST+1)  reads currently outstanding

Behaviour:
- One clock; rst_i is synchronous and active-high.
- Reset state:
  - FIFO empty, outst_cnt_o=0.
  - RR pointer=0, all age counters=0, grant lock cleared.
  - All valid/ready outputs are 0 (they derive from registered state plus inputs).
- Eligible set: slots with mst_ar_valid_i=1.
  - Class A: aged slots (age==AGE_THRESH, AGE_THRESH!=0).
  - Class B: all eligible slots, used only if class A is empty.
- Within class B the winner is the maximum QoS. Ties go to the first tied slot at or after rr_ptr, searching upward with wrap. Class A uses the same rotation and ignores QoS.
- Grant lock:
  - Once slv_ar_valid_o=1 without ar_ready, the granted slot is registered. The grant and address are held until handshake, with no re-arbitration even if a higher-QoS request arrives.
  - The lock clears on handshake.
- AR path:
  - slv_ar_valid_o = any eligible & !fifo_full.
  - slv_ar_addr_o = address of the granted slot.
  - mst_ar_ready_o[g] = slv_ar_ready_i & slv_ar_valid_o. This is combinational, with zero-cycle latency.
- On AR handshake:
  - Push g to the FIFO.
  - rr_ptr <= (g+1) mod NUM_MST.
  - age[g] <= 0.
- Aging, per slot each cycle:
  - If valid & not handshaken, age increments, saturating at AGE_THRESH.
  - If valid=0, age <= 0.
- FIFO full blocks AR, even if a pop occurs in the same cycle. There is no same-cycle bypass.
- R path:
  - Head h = FIFO head.
  - mst_r_valid_o[h] = slv_r_valid_i & !fifo_empty.
  - slv_r_ready_o = mst_r_ready_i[h] & !fifo_empty.
  - R handshake pops the FIFO.
  - With the FIFO empty, slv_r_ready_o=0 and mst_r_valid_o=0, so a stray response is stalled, not dropped.
  - Data and resp pass through combinationally.
- Push and pop in the same cycle (FIFO not full): outst_cnt_o is unchanged and pointers advance.
- outst_cnt_o is updated on the next edge after each handshake.
- NUM_MST=1: the arbiter degenerates to pass-through; rr_ptr stays at 0.
- Reset mid-transaction discards all outstanding entries. The slave must be reset alongside.

Test Plan:
- Single read: slot 2 valid, qos=3, addr=0x100, slave ready → same-cycle slv_ar_addr_o=0x100, mst_ar_ready_o=0b0100. R from slave → mst_r_valid_o=0b0100; outst_cnt_o goes 1 then 0.
- QoS: slots 0,1,3 valid with qos 2,7,7, rr_ptr=0 → slot 1 granted first, slot 3 second, slot 0 third. R responses return to slots 1,3,0 in that order.
- Grant lock: slot 0 (qos 1) valid with slave ar_ready=0 for 3 cycles, slot 1 (qos 15) arrives in cycle 1 → address stays slot 0's until handshake; slot 1 is granted next.
- Aging: AGE_THRESH=4, slot 3 qos 0 and slot 0 qos 15 continuously valid, slave always ready → slot 3 granted within 5 cycles of asserting valid.
- Full FIFO: MAX_OUTST=4, 4 grants with no R → slv_ar_valid_o=0 and outst_cnt_o=4. One R handshake → AR resumes the next cycle.
- Reset: assert rst_i with 2 outstanding → next cycle outst_cnt_o=0, all valids 0. A stray slv_r_valid_i then sees slv_r_ready_o=0.
